seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
Drives the board's 8-digit, common-anode seven-segment display from the CPU's segment outputs: max instruction address, ALU operands P/Q, result high/low and operation code. The display is time-multiplexed one digit at a time. Inputs are snapshotted at frame boundaries so a frame never shows a mix of old and new values. A debounced button cycles the display through three pages. It sits downstream of the CPU core at top level, next to the debounced user-interface inputs.

Parameters:
SCAN_DIV, 100000, clock cycles each digit is lit (1 kHz digit rate at 100 MHz); minimum 2; benches use 4.

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst_n  in  1  asynchronous active-low reset
i_page_next  in  1  debounced level from the page button; the block does its own rising-edge detect
i_halt  in  1  CPU halted flag
i_max_addr  in  8  highest loaded instruction address
i_alu_P  in  16  ALU operand P
i_alu_Q  in  16  ALU operand Q
i_result_low  in  16  ALU result, low half
i_result_high  in  16  ALU result, high half
i_alu_op  in  3  ALU operation code
o_an_n  out  8  digit anodes, active low; bit 0 is the rightmost digit
o_seg_n  out  7  cathodes a..g, active low; bit 0 = a, bit 6 = g
o_dp_n  out  1  decimal point, active low
o_page  out  2  current page index

Behaviour:
- Reset (async, immediate, also mid-scan):
  - prescaler = 0, digit_idx = 0, page = 0.
  - All shadow registers = 0; page_prev = 1, so a button held through reset does not advance the page.
  - o_an_n = 8'hFF, o_seg_n = 7'h7F, o_dp_n = 1.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit_idx increments 0..7, wrapping 7 -> 0.
- Snapshot: on the terminal count with digit_idx == 7, all value inputs latch into shadow registers together. The display only ever reads the shadows. The first frame after reset therefore shows zeros.
- Page select:
  - Rising edge = i_page_next & ~page_prev.
  - On an edge, page advances 0 -> 1 -> 2 -> 0, effective the next cycle.
  - A held level gives exactly one advance.
  - A page change takes effect on the next digit; it does not wait for a frame boundary.
- Digit content (digit 7 is leftmost):
  - Page 0: digits 7..4 = P hex (MSN at 7); digits 3..0 = Q hex; dp lit on digit 4 as separator.
  - Page 1: digits 7..4 = result_high hex; digits 3..0 = result_low hex.
  - Page 2: digit 7 = op (0-7); digits 6..2 blank (o_seg_n = 7'h7F); digits 1..0 = max_addr hex.
- Halt indicator: i_halt is sampled live, not snapshotted. When high, dp is lit on digit 0 on every page.
- Hex encoding, active-high a..g, output inverted:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Output timing:
  - o_an_n, o_seg_n and o_dp_n are registered and reflect the digit_idx/page of the previous cycle (latency 1).
  - Exactly one anode is low at any time after the first post-reset cycle; o_an_n = ~(1 << digit_idx).
  - Anode and cathode values switch in the same cycle.
- o_page is a direct register output.

Test Plan:
1. Reset and scan (SCAN_DIV=4):
   - During reset: o_an_n = FF, o_seg_n = 7F, o_dp_n = 1.
   - After release: o_an_n = FE for the first 4 cycles, then FD, FB, F7, EF, DF, BF, 7F, then wraps to FE.
2. Snapshot:
   - Apply P = 16'h1234, Q = 16'hABCD in mid-frame. The current frame still shows 0 (seg_n 7'h40).
   - Next frame: digit 7 shows '1' (seg_n 7'h79); digit 0 shows 'd' (seg_n 7'h21); o_dp_n = 0 only on digit 4.
3. Page button:
   - Hold i_page_next high for 100 cycles: o_page goes 0 -> 1 exactly once.
   - With result_high = 16'hDEAD, result_low = 16'hBEEF: digit 7 shows 'd' (seg_n 7'h21).
   - Two more pulses: o_page goes 2, then 0.
   - Held high through reset release: o_page stays 0.
4. Page 2:
   - op = 3'd5, max_addr = 8'h3C.
   - Digit 7 seg_n = 7'h12; digits 6..2 seg_n = 7'h7F; digit 1 seg_n = 7'h30; digit 0 seg_n = 7'h46.
5. Halt and mid-scan reset:
   - i_halt = 1: o_dp_n = 0 on digit 0 on pages 0, 1 and 2.
   - Assert i_rst_n low mid-digit: outputs are FF/7F/1 in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/seg_display_if.sv
// seg_display_if: CPU-side values in, display drive out, for the seven-segment controller.
interface seg_display_if;
    logic        i_page_next;
    logic        i_halt;
    logic [7:0]  i_max_addr;
    logic [15:0] i_alu_P;
    logic [15:0] i_alu_Q;
    logic [15:0] i_result_low;
    logic [15:0] i_result_high;
    logic [2:0]  i_alu_op;
    logic [7:0]  o_an_n;
    logic [6:0]  o_seg_n;
    logic        o_dp_n;
    logic [1:0]  o_page;
    modport master (
        output i_page_next, i_halt, i_max_addr, i_alu_P, i_alu_Q,
               i_result_low, i_result_high, i_alu_op,
        input  o_an_n, o_seg_n, o_dp_n, o_page
    );
    modport slave (
        input  i_page_next, i_halt, i_max_addr, i_alu_P, i_alu_Q,
               i_result_low, i_result_high, i_alu_op,
        output o_an_n, o_seg_n, o_dp_n, o_page
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: time-multiplexed 8-digit common-anode display driver with
// frame-aligned value snapshots and a three-page view selected by a button.
module seg_display_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    seg_display_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {PG_OPS, PG_RES, PG_SYS} page_t;
    page_t         page_q, page_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic          page_prev_q;
    logic [15:0]   p_q, q_q, rh_q, rl_q;
    logic [2:0]    op_q;
    logic [7:0]    addr_q;
    logic [7:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic          tc, snap;
    logic [1:0]    sel;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        sel     = digit_q[1:0];
        tc      = presc_q == PW'(SCAN_DIV - 1);
        snap    = tc && digit_q == 3'd7;
        presc_d = tc ? '0 : presc_q + 1'b1;
        digit_d = tc ? digit_q + 3'd1 : digit_q;
        page_d  = (bus.i_page_next && !page_prev_q)
                ? (page_q == PG_SYS ? PG_OPS : page_t'(page_q + 2'd1)) : page_q;
        nib     = page_q == PG_OPS ? (digit_q[2] ? p_q[{sel, 2'b00} +: 4] : q_q[{sel, 2'b00} +: 4])
                : page_q == PG_RES ? (digit_q[2] ? rh_q[{sel, 2'b00} +: 4] : rl_q[{sel, 2'b00} +: 4])
                : digit_q == 3'd7  ? {1'b0, op_q} : addr_q[{sel[0], 2'b00} +: 4];
        an_n_d  = ~(8'd1 << digit_q);
        seg_n_d = (page_q == PG_SYS && digit_q inside {[3'd2:3'd6]}) ? 7'h7F : ~hex7(nib);
        // halt is shown live on digit 0 regardless of page
        dp_n_d  = !((page_q == PG_OPS && digit_q == 3'd4) || (bus.i_halt && digit_q == 3'd0));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q     <= '0;
            digit_q     <= '0;
            page_q      <= PG_OPS;
            page_prev_q <= 1'b1;
            p_q         <= '0;
            q_q         <= '0;
            rh_q        <= '0;
            rl_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            an_n_q      <= 8'hFF;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            page_q      <= page_d;
            page_prev_q <= bus.i_page_next;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            if (snap) begin
                p_q    <= bus.i_alu_P;
                q_q    <= bus.i_alu_Q;
                rh_q   <= bus.i_result_high;
                rl_q   <= bus.i_result_low;
                op_q   <= bus.i_alu_op;
                addr_q <= bus.i_max_addr;
            end
        end
    end

    assign bus.o_an_n  = an_n_q;
    assign bus.o_seg_n = seg_n_q;
    assign bus.o_dp_n  = dp_n_q;
    assign bus.o_page  = page_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed table, hand sequences and random stimulus checked
// every cycle against a cycle-count based reference of the display.
module tb_seg_display_ctrl;
    localparam int SD = 4;
    localparam int FR = 8 * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_display_if bus();
    seg_display_ctrl #(.SCAN_DIV(SD)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // reference: digit position follows from cycles elapsed since reset
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          n;
    logic [1:0]  m_page;
    logic        m_prev;
    logic [15:0] s_p, s_q, s_rh, s_rl;
    logic [2:0]  s_op;
    logic [7:0]  s_addr;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    function automatic logic [6:0] ref_seg(input int pg, input int d);
        int v;
        if (pg == 2 && d >= 2 && d <= 6) return 7'h7F;
        if (pg == 0)      v = d >= 4 ? int'(s_p >> (4 * (d - 4))) % 16 : int'(s_q >> (4 * d)) % 16;
        else if (pg == 1) v = d >= 4 ? int'(s_rh >> (4 * (d - 4))) % 16 : int'(s_rl >> (4 * d)) % 16;
        else              v = d == 7 ? int'(s_op) : int'(s_addr >> (4 * d)) % 16;
        return ~hex_tab[v];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0; m_page <= 0; m_prev <= 1'b1;
            s_p <= 0; s_q <= 0; s_rh <= 0; s_rl <= 0; s_op <= 0; s_addr <= 0;
            e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1;
        end else begin
            e_an  <= ~(8'd1 << ((n / SD) % 8));
            e_seg <= ref_seg(int'(m_page), (n / SD) % 8);
            e_dp  <= !((m_page == 0 && (n / SD) % 8 == 4) || (bus.i_halt && (n / SD) % 8 == 0));
            if (n % FR == FR - 1) begin
                s_p <= bus.i_alu_P; s_q <= bus.i_alu_Q;
                s_rh <= bus.i_result_high; s_rl <= bus.i_result_low;
                s_op <= bus.i_alu_op; s_addr <= bus.i_max_addr;
            end
            if (bus.i_page_next && !m_prev) m_page <= m_page == 2 ? 2'd0 : m_page + 2'd1;
            m_prev <= bus.i_page_next;
            n <= n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("model", {14'd0, bus.o_an_n, bus.o_seg_n, bus.o_dp_n, bus.o_page},
              {14'd0, e_an, e_seg, e_dp, m_page});
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wait_an(input logic [7:0] a);
        for (int i = 0; i < 2 * FR && bus.o_an_n !== a; i++) tick();
        check("wait_an", {24'd0, bus.o_an_n}, {24'd0, a});
    endtask

    task automatic press();
        bus.i_page_next = 1'b1;
        ticks(2);
        bus.i_page_next = 1'b0;
        ticks(2);
    endtask

    task automatic set_page(input int p);
        for (int i = 0; i < 4 && int'(bus.o_page) != p; i++) press();
        check("set_page", {30'd0, bus.o_page}, p);
    endtask

    typedef struct {
        int         pg;
        int         d;
        logic       halt;
        logic [6:0] seg;
        logic       dp;
    } vec_t;
    vec_t tbl [15];

    initial begin
        logic [7:0] ea;
        tbl[0]  = '{0, 7, 1'b0, 7'h79, 1'b1};
        tbl[1]  = '{0, 4, 1'b0, 7'h19, 1'b0};
        tbl[2]  = '{0, 3, 1'b0, 7'h08, 1'b1};
        tbl[3]  = '{0, 0, 1'b0, 7'h21, 1'b1};
        tbl[4]  = '{0, 0, 1'b1, 7'h21, 1'b0};
        tbl[5]  = '{1, 7, 1'b0, 7'h21, 1'b1};
        tbl[6]  = '{1, 4, 1'b0, 7'h21, 1'b1};
        tbl[7]  = '{1, 3, 1'b0, 7'h03, 1'b1};
        tbl[8]  = '{1, 0, 1'b1, 7'h0E, 1'b0};
        tbl[9]  = '{2, 7, 1'b0, 7'h12, 1'b1};
        tbl[10] = '{2, 6, 1'b0, 7'h7F, 1'b1};
        tbl[11] = '{2, 2, 1'b0, 7'h7F, 1'b1};
        tbl[12] = '{2, 1, 1'b0, 7'h30, 1'b1};
        tbl[13] = '{2, 0, 1'b0, 7'h46, 1'b1};
        tbl[14] = '{2, 0, 1'b1, 7'h46, 1'b0};

        bus.i_page_next = 0; bus.i_halt = 0; bus.i_max_addr = 0; bus.i_alu_op = 0;
        bus.i_alu_P = 0; bus.i_alu_Q = 0; bus.i_result_low = 0; bus.i_result_high = 0;
        ticks(3);
        check("rst_an", {24'd0, bus.o_an_n}, 32'hFF);
        check("rst_seg", {25'd0, bus.o_seg_n}, 32'h7F);
        check("rst_dp", {31'd0, bus.o_dp_n}, 32'h1);
        check("rst_page", {30'd0, bus.o_page}, 32'h0);

        rst_n = 1'b1;
        for (int k = 0; k < 36; k++) begin
            tick();
            ea = ~(8'd1 << ((k / 4) % 8));
            check("scan_an", {24'd0, bus.o_an_n}, {24'd0, ea});
        end

        bus.i_alu_P = 16'h1234; bus.i_alu_Q = 16'hABCD;
        wait_an(8'h7F);
        check("old_frame_seg", {25'd0, bus.o_seg_n}, 32'h40);
        wait_an(8'hFE);
        wait_an(8'h7F);
        check("new_d7_seg", {25'd0, bus.o_seg_n}, 32'h79);
        wait_an(8'hFE);
        check("new_d0_seg", {25'd0, bus.o_seg_n}, 32'h21);
        check("new_d0_dp", {31'd0, bus.o_dp_n}, 32'h1);
        wait_an(8'hEF);
        check("new_d4_dp", {31'd0, bus.o_dp_n}, 32'h0);

        bus.i_result_high = 16'hDEAD; bus.i_result_low = 16'hBEEF;
        bus.i_alu_op = 3'd5; bus.i_max_addr = 8'h3C;
        bus.i_page_next = 1'b1;
        ticks(100);
        bus.i_page_next = 1'b0;
        check("hold_once", {30'd0, bus.o_page}, 32'h1);
        wait_an(8'hFE);
        wait_an(8'h7F);
        check("res_d7_seg", {25'd0, bus.o_seg_n}, 32'h21);
        press();
        check("pulse_p2", {30'd0, bus.o_page}, 32'h2);
        press();
        check("pulse_p0", {30'd0, bus.o_page}, 32'h0);

        foreach (tbl[i]) begin
            set_page(tbl[i].pg);
            bus.i_halt = tbl[i].halt;
            tick();
            ea = ~(8'd1 << tbl[i].d);
            wait_an(ea);
            check($sformatf("tbl%0d_seg", i), {25'd0, bus.o_seg_n}, {25'd0, tbl[i].seg});
            check($sformatf("tbl%0d_dp", i), {31'd0, bus.o_dp_n}, {31'd0, tbl[i].dp});
        end
        bus.i_halt = 1'b0;

        for (int k = 0; k < 1500; k++) begin
            tick();
            if ($urandom_range(0, 7) == 0) bus.i_alu_P = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_alu_Q = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_result_high = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_result_low = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_alu_op = 3'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_max_addr = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.i_page_next = ~bus.i_page_next;
            if ($urandom_range(0, 15) == 0) bus.i_halt = ~bus.i_halt;
        end

        bus.i_page_next = 1'b1;
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(50);
        check("held_rst_page", {30'd0, bus.o_page}, 32'h0);
        bus.i_page_next = 1'b0;

        ticks(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", {24'd0, bus.o_an_n}, 32'hFF);
        check("async_seg", {25'd0, bus.o_seg_n}, 32'h7F);
        check("async_dp", {31'd0, bus.o_dp_n}, 32'h1);
        tick();
        rst_n = 1'b1;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
